// File: rtl/mips_pkg.sv
// Shared widths and loader state encoding for the instruction-memory loader.
package mips_pkg;

  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam int unsigned BCNT_W          = 2;
  localparam int unsigned WCNT_W          = 6;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_RECV  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian 4-byte shift register: the first byte shifted in ends up in [31:24].
module byte_packer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               clear,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_full
);

  logic [BCNT_W-1:0]  cnt_q, cnt_d;
  logic [INSTR_W-1:0] word_q, word_d;

  // Shift a byte in on each enabled cycle; clear wins over shift.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (shift_en) begin
      word_d = {word_q[INSTR_W-BYTE_W-1:0], byte_in};
      cnt_d  = cnt_q + BCNT_W'(1);
    end
  end

  // Packing state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;
  // Flags the transfer that completes a word, so the FSM can leave RECV on that same edge.
  assign word_full = shift_en && (cnt_q == BCNT_W'(BYTES_PER_INSTR - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-streamed program into instruction memory, holding the CPU meanwhile.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [WCNT_W-1:0]  load_len,
  input  logic               byte_valid,
  input  logic [BYTE_W-1:0]  byte_data,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [INSTR_W-1:0] mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [WCNT_W-1:0]  word_count,
  output logic [INSTR_W-1:0] checksum
);

  localparam logic [1:0] S_IDLE  = 2'(LD_IDLE);
  localparam logic [1:0] S_RECV  = 2'(LD_RECV);
  localparam logic [1:0] S_WRITE = 2'(LD_WRITE);
  localparam logic [1:0] S_DONE  = 2'(LD_DONE);

  localparam logic [WCNT_W-1:0]  DEPTH_L = WCNT_W'(DEPTH);
  localparam logic [INSTR_W-1:0] BASE_L  = INSTR_W'(BASE_ADDR);
  localparam logic [INSTR_W-1:0] STEP_L  = INSTR_W'(BYTES_PER_INSTR);

  logic [1:0]         state_q, state_d;
  logic [WCNT_W-1:0]  len_q, len_d;
  logic [WCNT_W-1:0]  cnt_q, cnt_d;
  logic [INSTR_W-1:0] addr_q, addr_d;
  logic [INSTR_W-1:0] csum_q, csum_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               hold_q, hold_d;
  logic               ready_q, ready_d;
  logic               we_q, we_d;

  logic               start_ok;
  logic               xfer;
  logic [INSTR_W-1:0] pk_word;
  logic               pk_full;

  assign start_ok = load_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign xfer     = byte_valid && ready_q;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (xfer),
    .clear     (start_ok),
    .byte_in   (byte_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  // Next-state, counters and checksum; registered outputs decode from the next state.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          len_d  = load_len;
          cnt_d  = '0;
          csum_d = '0;
          addr_d = BASE_L;
          err_d  = 1'b0;
          if (load_len == '0) begin
            state_d = S_DONE;
          end else if (load_len > DEPTH_L) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (pk_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d   = cnt_q + WCNT_W'(1);
        csum_d  = csum_q ^ pk_word;
        addr_d  = addr_q + STEP_L;
        state_d = (cnt_d == len_q) ? S_DONE : S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_RECV);
    we_d    = (state_d == S_WRITE);
    hold_d  = (state_d == S_RECV) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      we_q    <= we_d;
    end
  end

  assign byte_ready = ready_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = pk_word;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = err_q;
  assign word_count = cnt_q;
  assign checksum   = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized directed bench for imem_loader with a word-list reference model.
module tb_imem_loader;

  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [5:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [5:0]  word_count;
  logic [31:0] checksum;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe is logged with its cycle number.
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          we_cyc[$];
  int          hold_bad_mon = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
      we_cyc.push_back(cyc);
      if (!cpu_hold) hold_bad_mon++;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_words[$];
  logic [7:0]  bq[$];
  int          exp_cyc[$];
  int          wr_base = 0;
  int          ld_bytes = 0;
  int          hold_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"},    32'(mem_we),     32'd0);
    chk({tag, "_addr"},  mem_addr,        32'd0);
    chk({tag, "_wdata"}, mem_wdata,       32'd0);
    chk({tag, "_hold"},  32'(cpu_hold),   32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_err"},   32'(error),      32'd0);
    chk({tag, "_wcnt"},  32'(word_count), 32'd0);
    chk({tag, "_csum"},  checksum,        32'd0);
  endtask

  // Big-endian byte stream for the expected word list.
  task automatic prep_bytes();
    logic [31:0] w;
    bq.delete();
    foreach (exp_words[i]) begin
      w = exp_words[i];
      bq.push_back(w[31:24]);
      bq.push_back(w[23:16]);
      bq.push_back(w[15:8]);
      bq.push_back(w[7:0]);
    end
  endtask

  task automatic start_load(input int len);
    exp_cyc.delete();
    wr_base   = wq_addr.size();
    ld_bytes  = 0;
    hold_bad  = 0;
    load_start = 1'b1;
    load_len   = 6'(len);
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic begin_load(input string tag, input int len);
    start_load(len);
    @(negedge clk);
    chk({tag, "_st_done"}, 32'(done),       32'd0);
    chk({tag, "_st_err"},  32'(error),      32'd0);
    chk({tag, "_st_wcnt"}, 32'(word_count), 32'd0);
    chk({tag, "_st_csum"}, checksum,        32'd0);
    chk({tag, "_st_hold"}, 32'(cpu_hold),   32'd1);
    @(posedge clk); #1;
  endtask

  task automatic feed(input string tag, input int budget, input int gap_pct,
                      input int stall_after, input int stall_cyc, input int max_bytes);
    int   n = 0;
    int   stall_left = 0;
    int   c = 0;
    int   want;
    logic took;
    want = (bq.size() < max_bytes) ? bq.size() : max_bytes;
    while (bq.size() > 0 && n < max_bytes && c < budget) begin
      if (stall_left > 0) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        stall_left--;
      end else begin
        byte_valid = ($urandom_range(99) >= gap_pct);
        byte_data  = bq[0];
      end
      @(negedge clk);
      if (!cpu_hold) hold_bad++;
      took = byte_valid && byte_ready;
      if (took && ((ld_bytes + 1) % 4 == 0)) exp_cyc.push_back(cyc + 1);
      @(posedge clk); #1;
      c++;
      if (took) begin
        void'(bq.pop_front());
        n++;
        ld_bytes++;
        if (n == stall_after) stall_left = stall_cyc;
      end
    end
    byte_valid = 1'b0;
    chk({tag, "_fed"}, 32'(n), 32'(want));
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic verify(input string tag, input int len);
    logic [31:0] cs = 32'h0;
    int          nw;
    nw = wq_addr.size() - wr_base;
    chk({tag, "_nwr"}, 32'(nw), 32'(exp_words.size()));
    chk({tag, "_nlat"}, 32'(exp_cyc.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < nw; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wq_addr[wr_base + i], BASE + 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), wq_data[wr_base + i], exp_words[i]);
      if (i < exp_cyc.size())
        chk($sformatf("%s_lat%0d", tag, i), 32'(we_cyc[wr_base + i]), 32'(exp_cyc[i]));
    end
    foreach (exp_words[i]) cs = cs ^ exp_words[i];
    chk({tag, "_wcnt"},    32'(word_count), 32'(len));
    chk({tag, "_csum"},    checksum,        cs);
    chk({tag, "_done"},    32'(done),       32'd1);
    chk({tag, "_err"},     32'(error),      32'd0);
    chk({tag, "_hold"},    32'(cpu_hold),   32'd0);
    chk({tag, "_ready"},   32'(byte_ready), 32'd0);
    chk({tag, "_holdrun"}, 32'(hold_bad),   32'd0);
    chk({tag, "_holdwe"},  32'(hold_bad_mon), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input string tag, input int gap_pct,
                          input int stall_after, input int stall_cyc);
    prep_bytes();
    begin_load(tag, exp_words.size());
    feed(tag, 4000, gap_pct, stall_after, stall_cyc, 1000);
    wait_done(tag, 20);
    verify(tag, exp_words.size());
  endtask

  initial begin
    int          len;
    int          rdy_seen;
    logic [31:0] first;

    reset      = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;

    // Single word, no gaps.
    exp_words.delete();
    exp_words.push_back(32'h8C010004);
    run_load("one", 0, 0, 0);

    // Zero length: done next cycle, nothing written.
    start_load(0);
    @(negedge clk);
    chk("len0_done", 32'(done),     32'd1);
    chk("len0_err",  32'(error),    32'd0);
    chk("len0_hold", 32'(cpu_hold), 32'd0);
    chk("len0_wcnt", 32'(word_count), 32'd0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("len0_nwr", 32'(wq_addr.size() - wr_base), 32'd0);

    // Oversize length: error, no hold, bytes refused.
    start_load(40);
    @(negedge clk);
    chk("len40_done", 32'(done),     32'd1);
    chk("len40_err",  32'(error),    32'd1);
    chk("len40_hold", 32'(cpu_hold), 32'd0);
    @(posedge clk); #1;
    rdy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(negedge clk);
      if (byte_ready) rdy_seen++;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("len40_ready", 32'(rdy_seen), 32'd0);
    chk("len40_nwr", 32'(wq_addr.size() - wr_base), 32'd0);

    // Three known words with random gaps; the start clears error.
    exp_words.delete();
    exp_words.push_back(32'h8C010004);
    exp_words.push_back(32'h8C220005);
    exp_words.push_back(32'h00225020);
    run_load("three", 40, 0, 0);

    // Back-pressure: 7 idle cycles after the second byte.
    exp_words.delete();
    exp_words.push_back($urandom);
    run_load("stall", 0, 2, 7);

    // Reset in the middle of a 2-word load, then a fresh 1-word load.
    exp_words.delete();
    exp_words.push_back($urandom);
    exp_words.push_back($urandom);
    first = exp_words[0];
    prep_bytes();
    begin_load("rstmid", 2);
    feed("rstmid", 200, 20, 0, 0, 6);
    chk("rstmid_nwr", 32'(wq_addr.size() - wr_base), 32'd1);
    if (wq_addr.size() > wr_base) chk("rstmid_w0", wq_data[wr_base], first);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("rstmid");
    @(posedge clk); #1;
    exp_words.delete();
    exp_words.push_back($urandom);
    run_load("afterrst", 10, 0, 0);

    // Start pulse during a load is ignored.
    exp_words.delete();
    exp_words.push_back($urandom);
    exp_words.push_back($urandom);
    prep_bytes();
    begin_load("midstart", 2);
    feed("midstart_a", 200, 0, 0, 0, 3);
    load_start = 1'b1;
    load_len   = 6'd5;
    @(posedge clk); #1;
    load_start = 1'b0;
    load_len   = 6'd0;
    feed("midstart_b", 400, 30, 0, 0, 1000);
    wait_done("midstart", 20);
    verify("midstart", 2);

    // Random programs, first one at full depth.
    for (int k = 0; k < 4; k++) begin
      len = (k == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
      exp_words.delete();
      for (int i = 0; i < len; i++) exp_words.push_back($urandom);
      run_load($sformatf("rnd%0d", k), int'($urandom_range(0, 60)), 0, 0);
    end

    // One past the depth limit is rejected.
    start_load(DEPTH + 1);
    @(negedge clk);
    chk("len33_done", 32'(done),     32'd1);
    chk("len33_err",  32'(error),    32'd1);
    chk("len33_hold", 32'(cpu_hold), 32'd0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    chk("len33_nwr", 32'(wq_addr.size() - wr_base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
